// File: rtl/sc_timer_io.sv
// Memory-mapped prescaled countdown timer sitting on the CPU data bus.
// It has one-shot and auto-reload modes, a sticky expiry flag and a level interrupt.
//
// state  | meaning
// S_IDLE | timer disabled (CTRL.EN=0), no counting
// S_RUN  | prescaler running, COUNT decrements on each tick
// S_DONE | one-shot expired, EN cleared by hardware, waiting for software
module sc_timer_io #(
  parameter logic [31:0] BASE    = 32'hFFFF_FF00,
  parameter int          COUNT_W = 32,
  parameter int          PRE_W   = 16
) (
  input  logic        i_clock,
  input  logic        i_resetn,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  output logic        o_sel,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_ctrl;
  logic [COUNT_W-1:0] r_load;
  logic [COUNT_W-1:0] r_count;
  logic               r_exp;
  logic [PRE_W-1:0]   r_pre;
  logic [PRE_W-1:0]   r_pre_cnt;

  logic [31:0] w_off;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_load_wr;
  logic        w_count_wr;
  logic        w_stat_wr;
  logic        w_pre_wr;
  logic        w_tick;
  logic        w_expire;
  logic        w_oneshot;
  logic [31:0] w_count_ext;
  logic [31:0] w_load_ext;
  logic [31:0] w_pre_ext;
  logic        w_unused_ok;

  // The offset is computed by subtraction, so BASE does not need to be window-aligned.
  assign w_off = i_addr - BASE;
  assign o_sel = (i_addr >= BASE) && (w_off < 32'h20);
  assign w_idx = w_off[4:2];

  assign w_wr       = i_we & o_sel;
  assign w_ctrl_wr  = w_wr && (w_idx == 3'd0);
  assign w_load_wr  = w_wr && (w_idx == 3'd1);
  assign w_count_wr = w_wr && (w_idx == 3'd2);
  assign w_stat_wr  = w_wr && (w_idx == 3'd3);
  assign w_pre_wr   = w_wr && (w_idx == 3'd4);

  // A CPU write to COUNT consumes the tick entirely, so no expiry occurs on that edge.
  assign w_tick    = (r_state == S_RUN) && (r_pre_cnt == r_pre);
  assign w_expire  = w_tick && (r_count == '0) && !w_count_wr;
  assign w_oneshot = w_expire && !r_ctrl[1];

  assign o_irq       = r_exp & r_ctrl[2];
  assign w_unused_ok = &{1'b0, w_off[1:0], i_wdata};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ctrl_wr && i_wdata[0]) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_ctrl_wr)      w_next = i_wdata[0] ? S_RUN : S_IDLE;
        else if (w_oneshot) w_next = S_DONE;
      end
      S_DONE: begin
        if (w_ctrl_wr) w_next = i_wdata[0] ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_load    <= '0;
      r_count   <= '0;
      r_exp     <= 1'b0;
      r_pre     <= '0;
      r_pre_cnt <= '0;
    end else begin
      r_state <= w_next;

      if (w_ctrl_wr)      r_ctrl    <= i_wdata[2:0];
      else if (w_oneshot) r_ctrl[0] <= 1'b0;

      if (w_load_wr) r_load <= i_wdata[COUNT_W-1:0];
      if (w_pre_wr)  r_pre  <= i_wdata[PRE_W-1:0];

      if (w_count_wr) begin
        r_count <= i_wdata[COUNT_W-1:0];
      end else if (w_tick) begin
        if (r_count != '0) r_count <= r_count - COUNT_W'(1);
        else if (r_ctrl[1]) r_count <= r_load;
      end

      if (w_expire)                  r_exp <= 1'b1;
      else if (w_stat_wr && i_wdata[0]) r_exp <= 1'b0;

      if ((w_ctrl_wr && i_wdata[0]) || (w_next != S_RUN)) r_pre_cnt <= '0;
      else if (w_tick)                                    r_pre_cnt <= '0;
      else                                                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

  always_comb begin
    w_count_ext = '0;
    w_load_ext  = '0;
    w_pre_ext   = '0;
    w_count_ext[COUNT_W-1:0] = r_count;
    w_load_ext[COUNT_W-1:0]  = r_load;
    w_pre_ext[PRE_W-1:0]     = r_pre;
  end

  always_comb begin
    o_rdata = '0;
    if (o_sel) begin
      case (w_idx)
        3'd0:    o_rdata = {29'd0, r_ctrl};
        3'd1:    o_rdata = w_load_ext;
        3'd2:    o_rdata = w_count_ext;
        3'd3:    o_rdata = {31'd0, r_exp};
        3'd4:    o_rdata = w_pre_ext;
        default: o_rdata = '0;
      endcase
    end
  end

endmodule
